// File: rtl/calc_pkg.sv
// Shared key codes, FSM state encodings, error codes and the single-cycle ALU
// used by the calculator sequencer.
package calc_pkg;

    // Widest operand the shared ALU function supports; instances must keep W within it.
    localparam int unsigned CALC_MAX_W = 32;

    typedef enum logic [2:0] {
        KEY_NOP   = 3'b000,
        KEY_NUM   = 3'b001,
        KEY_ENTER = 3'b010,
        KEY_CLEAR = 3'b011,
        KEY_ADD   = 3'b100,
        KEY_SUB   = 3'b101,
        KEY_MUL   = 3'b110,
        KEY_DIV   = 3'b111
    } key_code_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ENTRY_A = 3'd1,
        ST_OP_WAIT = 3'd2,
        ST_ENTRY_B = 3'd3,
        ST_EXEC    = 3'd4,
        ST_SHOW    = 3'd5,
        ST_ERR     = 3'd6
    } calc_state_e;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_OVF  = 2'b01;
    localparam logic [1:0] ERR_UNF  = 2'b10;
    localparam logic [1:0] ERR_DIV0 = 2'b11;

    typedef struct packed {
        logic [CALC_MAX_W-1:0] res;
        logic [1:0]            err;
    } alu_res_t;

    function automatic logic is_operator(input key_code_e code);
        return code[2];
    endfunction

    // Unsigned w-bit add/sub/mul; anything spilling above bit w-1 is an overflow.
    function automatic alu_res_t calc_alu(input key_code_e op,
                                          input logic [CALC_MAX_W-1:0] a,
                                          input logic [CALC_MAX_W-1:0] b,
                                          input int unsigned w);
        logic [2*CALC_MAX_W-1:0] a_ext;
        logic [2*CALC_MAX_W-1:0] b_ext;
        logic [2*CALC_MAX_W-1:0] wide;
        alu_res_t r;
        a_ext = {{CALC_MAX_W{1'b0}}, a};
        b_ext = {{CALC_MAX_W{1'b0}}, b};
        r.err = ERR_NONE;
        wide  = '0;
        case (op)
            KEY_ADD: begin
                wide = a_ext + b_ext;
                if ((wide >> w) != '0) r.err = ERR_OVF;
            end
            KEY_SUB: begin
                wide = a_ext - b_ext;
                if (b > a) r.err = ERR_UNF;
            end
            KEY_MUL: begin
                wide = a_ext * b_ext;
                if ((wide >> w) != '0) r.err = ERR_OVF;
            end
            default: wide = '0;
        endcase
        r.res = wide[CALC_MAX_W-1:0];
        return r;
    endfunction

endpackage

// File: rtl/calc_seq_if.sv
// Keypad-side handshake and display-side outputs of the calculator sequencer.
interface calc_seq_if #(
    parameter int unsigned W = 8
);
    logic         key_valid;
    logic [2:0]   key_code;
    logic [W-1:0] key_data;
    logic         key_ready;
    logic [W-1:0] disp_val;
    logic         disp_sel;
    logic [2:0]   state_o;
    logic         err;
    logic [1:0]   err_code;
    logic         result_valid;

    modport slave (
        input  key_valid, key_code, key_data,
        output key_ready, disp_val, disp_sel, state_o, err, err_code, result_valid
    );

    modport master (
        output key_valid, key_code, key_data,
        input  key_ready, disp_val, disp_sel, state_o, err, err_code, result_valid
    );
endinterface

// File: rtl/calc_div.sv
// Restoring unsigned divider: start loads operands, then W iterations one per cycle.
// done is high during the final iteration, with quotient already showing that step's result.
module calc_div #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient
);
    localparam int unsigned CW = $clog2(W + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  rem_q, rem_d;
    logic [W-1:0]  quo_q, quo_d;
    logic [W-1:0]  dvs_q, dvs_d;

    logic [W:0]    shifted;
    logic [W:0]    trial;
    logic          fits;
    logic [W-1:0]  rem_nx;
    logic [W-1:0]  quo_nx;

    // Partial remainder stays below the divisor, so bit W of the trial is a pure borrow.
    always_comb begin
        shifted = {rem_q, quo_q[W-1]};
        trial   = shifted - {1'b0, dvs_q};
        fits    = ~trial[W];
        rem_nx  = fits ? trial[W-1:0] : shifted[W-1:0];
        quo_nx  = {quo_q[W-2:0], fits};
    end

    assign busy     = (cnt_q != '0);
    assign done     = (cnt_q == CW'(1));
    assign quotient = quo_nx;

    always_comb begin
        cnt_d = cnt_q;
        rem_d = rem_q;
        quo_d = quo_q;
        dvs_d = dvs_q;
        if (start) begin
            cnt_d = CW'(W);
            rem_d = '0;
            quo_d = dividend;
            dvs_d = divisor;
        end else if (busy) begin
            cnt_d = cnt_q - CW'(1);
            rem_d = rem_nx;
            quo_d = quo_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
        end
    end

endmodule

// File: rtl/calc_seq.sv
// Calculator sequencer: key-event FSM, operand/accumulator/operator registers and ALU.
// EXEC takes 1 cycle (W+1 for divide); key_ready drops only while in EXEC.
module calc_seq
    import calc_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic          clk,
    input  logic          reset,
    calc_seq_if.slave     io
);

    calc_state_e  state_q, state_d;
    logic [W-1:0] opnd_q, opnd_d;
    logic [W-1:0] acc_q, acc_d;
    key_code_e    op_q, op_d;
    key_code_e    nxt_op_q, nxt_op_d;
    logic         chain_q, chain_d;
    logic [1:0]   err_code_q, err_code_d;
    logic         rv_q, rv_d;

    logic         key_ready;
    logic         accept;
    key_code_e    code;
    alu_res_t     alu_r;

    logic         div_start;
    logic         div_busy;
    logic         div_done;
    logic [W-1:0] div_quotient;

    calc_div #(.W(W)) u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .dividend (acc_q),
        .divisor  (opnd_q),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quotient)
    );

    assign key_ready = (state_q != ST_EXEC);
    assign accept    = io.key_valid && key_ready;
    assign code      = key_code_e'(io.key_code);

    always_comb begin
        alu_r = calc_alu(op_q, CALC_MAX_W'(acc_q), CALC_MAX_W'(opnd_q), W);
    end

    always_comb begin
        state_d    = state_q;
        opnd_d     = opnd_q;
        acc_d      = acc_q;
        op_d       = op_q;
        nxt_op_d   = nxt_op_q;
        chain_d    = chain_q;
        err_code_d = err_code_q;
        rv_d       = 1'b0;
        div_start  = 1'b0;

        if (state_q == ST_EXEC) begin
            if (op_q == KEY_DIV) begin
                // First EXEC cycle is divider setup; busy marks the iteration cycles.
                if (!div_busy) begin
                    if (opnd_q == '0) begin
                        state_d    = ST_ERR;
                        err_code_d = ERR_DIV0;
                    end else begin
                        div_start = 1'b1;
                    end
                end else if (div_done) begin
                    acc_d   = div_quotient;
                    rv_d    = 1'b1;
                    state_d = chain_q ? ST_OP_WAIT : ST_SHOW;
                    if (chain_q) op_d = nxt_op_q;
                end
            end else if (alu_r.err != ERR_NONE) begin
                state_d    = ST_ERR;
                err_code_d = alu_r.err;
            end else begin
                acc_d   = W'(alu_r.res);
                rv_d    = 1'b1;
                state_d = chain_q ? ST_OP_WAIT : ST_SHOW;
                if (chain_q) op_d = nxt_op_q;
            end
        end else if (accept) begin
            if (code == KEY_CLEAR) begin
                opnd_d     = '0;
                acc_d      = '0;
                op_d       = KEY_ADD;
                err_code_d = ERR_NONE;
                state_d    = ST_IDLE;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (code == KEY_NUM) begin
                            opnd_d  = io.key_data;
                            state_d = ST_ENTRY_A;
                        end
                    end
                    ST_ENTRY_A: begin
                        if (code == KEY_NUM) begin
                            opnd_d = io.key_data;
                        end else if (code == KEY_ENTER) begin
                            acc_d   = opnd_q;
                            state_d = ST_SHOW;
                        end else if (is_operator(code)) begin
                            acc_d   = opnd_q;
                            op_d    = code;
                            state_d = ST_OP_WAIT;
                        end
                    end
                    ST_OP_WAIT: begin
                        if (is_operator(code)) begin
                            op_d = code;
                        end else if (code == KEY_NUM) begin
                            opnd_d  = io.key_data;
                            state_d = ST_ENTRY_B;
                        end else if (code == KEY_ENTER) begin
                            state_d = ST_SHOW;
                        end
                    end
                    ST_ENTRY_B: begin
                        if (code == KEY_NUM) begin
                            opnd_d = io.key_data;
                        end else if (code == KEY_ENTER) begin
                            chain_d = 1'b0;
                            state_d = ST_EXEC;
                        end else if (is_operator(code)) begin
                            nxt_op_d = code;
                            chain_d  = 1'b1;
                            state_d  = ST_EXEC;
                        end
                    end
                    ST_SHOW: begin
                        if (code == KEY_NUM) begin
                            opnd_d  = io.key_data;
                            state_d = ST_ENTRY_A;
                        end else if (is_operator(code)) begin
                            op_d    = code;
                            state_d = ST_OP_WAIT;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            opnd_q     <= '0;
            acc_q      <= '0;
            op_q       <= KEY_ADD;
            nxt_op_q   <= KEY_ADD;
            chain_q    <= 1'b0;
            err_code_q <= ERR_NONE;
            rv_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            opnd_q     <= opnd_d;
            acc_q      <= acc_d;
            op_q       <= op_d;
            nxt_op_q   <= nxt_op_d;
            chain_q    <= chain_d;
            err_code_q <= err_code_d;
            rv_q       <= rv_d;
        end
    end

    logic disp_sel;
    assign disp_sel = (state_q == ST_OP_WAIT) || (state_q == ST_SHOW) || (state_q == ST_EXEC);

    always_comb begin
        io.disp_val = '0;
        if (state_q != ST_IDLE && state_q != ST_ERR) begin
            io.disp_val = disp_sel ? acc_q : opnd_q;
        end
    end

    assign io.key_ready    = key_ready;
    assign io.disp_sel     = disp_sel;
    assign io.state_o      = state_q;
    assign io.err          = (state_q == ST_ERR);
    assign io.err_code     = err_code_q;
    assign io.result_valid = rv_q;

endmodule
